display_inputs_scanner: RTL and testbench



---
 rtl/display_inputs_pkg.sv | 25 ++
 rtl/display_inputs_scanner_quad_decoder.sv | 63 ++++++
 rtl/display_inputs_scanner.sv | 197 +++++++++++++++++++
 tb/tb_display_inputs_scanner.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_inputs_pkg.sv
// rtl/display_inputs_pkg.sv - register map, control bits and scan FSM states for display_inputs_scanner
//
// Shared by the scanner top and its testbench:
//   REG_*          Avalon-MM word addresses
//   CTRL_*         bit positions inside the CTRL register
//   scan_state_t   states of the shift-register scan FSM
package display_inputs_pkg;

  localparam logic [2:0] REG_BUTTONS = 3'd0;
  localparam logic [2:0] REG_EVENTS  = 3'd1;
  localparam logic [2:0] REG_DIALS   = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_ERR     = 3'd4;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CLEAR  = 1;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } scan_state_t;

endpackage

// File: rtl/display_inputs_scanner_quad_decoder.sv
// rtl/display_inputs_scanner_quad_decoder.sv - x4 quadrature decoder with sticky illegal-step flag
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   a, b           raw asynchronous quadrature phases
//   clear          zero the count (wins over a simultaneous step)
//   err_clr        clear the sticky err flag (loses to a simultaneous set)
//   count          signed x4 count, wraps modulo 2^COUNT_W
//   err            sticky flag: both phases changed in one step
module quad_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               a,
  input  logic               b,
  input  logic               clear,
  input  logic               err_clr,
  output logic [COUNT_W-1:0] count,
  output logic               err
);

  logic a_s1, a_s2, b_s1, b_s2;
  logic a_q, b_q;
  logic a_chg, b_chg, up;

  assign a_chg = a_s2 ^ a_q;
  assign b_chg = b_s2 ^ b_q;
  // A-leads sequence is 00->10->11->01: when A moves it ends up differing
  // from B, when B moves it ends up equal to A.
  assign up = a_chg ? (a_s2 != b_q) : (b_s2 == a_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s1  <= 1'b0;
      a_s2  <= 1'b0;
      b_s1  <= 1'b0;
      b_s2  <= 1'b0;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      a_s1 <= a;
      a_s2 <= a_s1;
      b_s1 <= b;
      b_s2 <= b_s1;
      a_q  <= a_s2;
      b_q  <= b_s2;

      if (clear)
        count <= '0;
      else if (a_chg ^ b_chg)
        count <= up ? count + 1'b1 : count - 1'b1;

      if (a_chg && b_chg)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/display_inputs_scanner.sv
// rtl/display_inputs_scanner.sv - button shift-register scanner, debouncer and dial counters on Avalon-MM
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   shift_load              parallel load to the button shift register, active low
//   shift_clkin             shift clock to the button shift register
//   shift_out               serial button data, raw 0 = pressed
//   dial_a, dial_b          quadrature phases, one bit per dial
//   avs_address/read/write  Avalon-MM slave, word addressed, no waitrequest
//   avs_writedata           write data
//   avs_readdata            registered read data, valid the cycle after avs_read
//   irq                     level interrupt: irq_en & any press event
module display_inputs_scanner
  import display_inputs_pkg::*;
#(
  parameter int NUM_BUTTONS    = 16,
  parameter int NUM_DIALS      = 2,
  parameter int COUNT_W        = 8,
  parameter int SHIFT_DIV      = 25,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 shift_load,
  output logic                 shift_clkin,
  input  logic                 shift_out,
  input  logic [NUM_DIALS-1:0] dial_a,
  input  logic [NUM_DIALS-1:0] dial_b,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq
);

  localparam int CNT_W = $clog2(2 * SHIFT_DIV);
  localparam int BIT_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  scan_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [NUM_BUTTONS-1:0] raw;
  logic                   so_s1, so_s2;
  logic                   scan_done;

  logic [NUM_BUTTONS-1:0] pressed, deb, flip, ev_set, ev_clr, events;
  logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];

  logic                         irq_en;
  logic                         ctrl_wr, dial_clear;
  logic [NUM_DIALS-1:0]         err_clr, dial_err;
  logic [NUM_DIALS*COUNT_W-1:0] dial_counts;
  logic [31:0]                  rd_word;
  logic                         unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Scan FSM. Outputs are registered from the current state, so the pin
  // waveform trails the state by one cycle but every phase keeps its width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD;
      cnt         <= '0;
      bit_idx     <= '0;
      raw         <= '0;
      so_s1       <= 1'b0;
      so_s2       <= 1'b0;
      shift_load  <= 1'b1;
      shift_clkin <= 1'b0;
    end else begin
      so_s1       <= shift_out;
      so_s2       <= so_s1;
      shift_load  <= !(state == LOAD && cnt < CNT_W'(SHIFT_DIV));
      shift_clkin <= (state == SHIFT_HI);
      case (state)
        LOAD: begin
          if (cnt == CNT_W'(2 * SHIFT_DIV - 1)) begin
            cnt     <= '0;
            bit_idx <= BIT_W'(NUM_BUTTONS - 1);
            state   <= SHIFT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_LO: begin
          if (cnt == CNT_W'(SHIFT_DIV - 1)) begin
            raw[bit_idx] <= so_s2;
            cnt          <= '0;
            state        <= SHIFT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (cnt == CNT_W'(SHIFT_DIV - 1)) begin
            cnt <= '0;
            if (bit_idx == '0) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= LOAD;
        end
      endcase
    end
  end

  assign scan_done = (state == DONE);
  assign pressed   = ~raw;

  // A button flips on the scan that completes its run of disagreeing scans.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      flip[i] = scan_done && (pressed[i] != deb[i]) &&
                (db_cnt[i] == DB_W'(DEBOUNCE_SCANS - 1));
  end

  assign ev_set = flip & pressed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
        db_cnt[i] <= '0;
    end else if (scan_done) begin
      deb <= deb ^ flip;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (pressed[i] == deb[i] || flip[i])
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign ctrl_wr    = avs_write && (avs_address == REG_CTRL);
  assign dial_clear = ctrl_wr && avs_writedata[CTRL_CLEAR];
  assign ev_clr     = (avs_write && avs_address == REG_EVENTS) ?
                      avs_writedata[NUM_BUTTONS-1:0] : '0;
  assign err_clr    = (avs_write && avs_address == REG_ERR) ?
                      avs_writedata[NUM_DIALS-1:0] : '0;

  for (genvar g = 0; g < NUM_DIALS; g++) begin : g_dial
    quad_decoder #(
      .COUNT_W(COUNT_W)
    ) u_dec (
      .clk    (clk),
      .reset_n(reset_n),
      .a      (dial_a[g]),
      .b      (dial_b[g]),
      .clear  (dial_clear),
      .err_clr(err_clr[g]),
      .count  (dial_counts[g*COUNT_W +: COUNT_W]),
      .err    (dial_err[g])
    );
  end

  always_comb begin
    rd_word = '0;
    case (avs_address)
      REG_BUTTONS: rd_word = 32'(deb);
      REG_EVENTS:  rd_word = 32'(events);
      REG_DIALS:   rd_word = 32'(dial_counts);
      REG_CTRL:    rd_word = {31'b0, irq_en};
      REG_ERR:     rd_word = 32'(dial_err);
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events       <= '0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      // A set landing on the same cycle as its W1C survives.
      events <= (events & ~ev_clr) | ev_set;
      if (ctrl_wr)
        irq_en <= avs_writedata[CTRL_IRQ_EN];
      irq <= irq_en & (|events);
      if (avs_read)
        avs_readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_display_inputs_scanner.sv
// tb/tb_display_inputs_scanner.sv - directed self-checking bench for display_inputs_scanner
module tb_display_inputs_scanner;
  import display_inputs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        shift_load, shift_clkin, shift_out;
  logic [1:0]  dial_a = 2'b00, dial_b = 2'b00;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;
  int dpos [2] = '{0, 0};

  logic [15:0] par = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;
  logic        prev_clkin = 1'b0;

  always #10 clk = ~clk;

  display_inputs_scanner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .shift_load   (shift_load),
    .shift_clkin  (shift_clkin),
    .shift_out    (shift_out),
    .dial_a       (dial_a),
    .dial_b       (dial_b),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  // 165-style parallel-in serial-out register: loads while shift_load is low,
  // shifts toward the MSB output on each rising shift_clkin.
  always @(posedge clk) begin
    prev_clkin <= shift_clkin;
    if (!shift_load)
      sr <= par;
    else if (shift_clkin && !prev_clkin)
      sr <= {sr[14:0], 1'b1};
  end
  assign shift_out = sr[15];

  task automatic rd(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data     = avs_readdata;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  // Returns just after the clock edge on which shift_load goes low.
  task automatic wait_fall();
    bit seen_high = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (shift_load) begin
        seen_high = 1'b1;
      end else if (seen_high) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_fall: shift_load low edge not seen within 2000 cycles");
    end
  endtask

  task automatic step_dial(input int d, input int dir);
    dpos[d] = (dpos[d] + dir) & 3;
    @(negedge clk);
    dial_a[d] = (dpos[d] == 1) || (dpos[d] == 2);
    dial_b[d] = (dpos[d] == 2) || (dpos[d] == 3);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (shift_load !== 1'b1) begin n_fail++; $display("FAIL reset_shift_load: got %b expected 1", shift_load); end
    n_checks++;
    if (shift_clkin !== 1'b0) begin n_fail++; $display("FAIL reset_shift_clkin: got %b expected 0", shift_clkin); end
    n_checks++;
    if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", avs_readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", a, d); end
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    wr(REG_CTRL, 32'h1);
    wait_fall();
    par = 16'hFFFE;
    repeat (3) wait_fall();
    rd(REG_BUTTONS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL press_after3: got %h expected 0", d); end
    wait_fall();
    rd(REG_BUTTONS, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL press_buttons: got %h expected 1", d); end
    rd(REG_EVENTS, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL press_events: got %h expected 1", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b expected 1", irq); end
    wr(REG_EVENTS, 32'h1);
    rd(REG_EVENTS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL press_w1c: got %h expected 0", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_clr: got %b expected 0", irq); end
    wait_fall();
    par = 16'hFFFF;
    repeat (4) wait_fall();
    rd(REG_BUTTONS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL release_buttons: got %h expected 0", d); end
    rd(REG_EVENTS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL release_events: got %h expected 0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    wait_fall();
    par = 16'hFFF7;
    repeat (2) wait_fall();
    par = 16'hFFFF;
    repeat (3) wait_fall();
    rd(REG_BUTTONS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_buttons: got %h expected 0", d); end
    rd(REG_EVENTS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_events: got %h expected 0", d); end
  endtask

  task automatic test_event_w1c_collision();
    logic [31:0] d;
    wait_fall();
    par = 16'hFFFE;
    repeat (3) wait_fall();
    // Fourth scan's DONE edge is 850 edges after this shift_load fall.
    repeat (849) @(posedge clk);
    #1;
    avs_address   = REG_EVENTS;
    avs_writedata = 32'h1;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    rd(REG_EVENTS, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL event_set_wins: got %h expected 1", d); end
    rd(REG_BUTTONS, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL event_buttons: got %h expected 1", d); end
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd7, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
  endtask

  task automatic test_dial_count();
    logic [31:0] d;
    for (int i = 0; i < 20; i++) step_dial(0, 1);
    rd(REG_DIALS, d);
    n_checks++;
    if (d !== 32'h0000_0014) begin n_fail++; $display("FAIL dial_up: got %h expected 00000014", d); end
    for (int i = 0; i < 21; i++) step_dial(0, -1);
    rd(REG_DIALS, d);
    n_checks++;
    if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL dial_down: got %h expected 000000ff", d); end
  endtask

  task automatic test_dial_err();
    logic [31:0] d;
    @(negedge clk);
    dial_a[1] = 1'b1;
    dial_b[1] = 1'b1;
    repeat (5) @(negedge clk);
    rd(REG_DIALS, d);
    n_checks++;
    if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL err_count: got %h expected 000000ff", d); end
    rd(REG_ERR, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL err_set: got %h expected 2", d); end
    wr(REG_ERR, 32'h2);
    rd(REG_ERR, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL err_w1c: got %h expected 0", d); end
    @(negedge clk);
    dial_a[1] = 1'b0;
    dial_b[1] = 1'b0;
    repeat (5) @(negedge clk);
    wr(REG_ERR, 32'h2);
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    // Dial 0 steps backwards; the count lands 3 edges later, with the clear.
    @(posedge clk);
    #1;
    dpos[0] = (dpos[0] - 1) & 3;
    dial_a[0] = (dpos[0] == 1) || (dpos[0] == 2);
    dial_b[0] = (dpos[0] == 2) || (dpos[0] == 3);
    repeat (2) @(posedge clk);
    #1;
    avs_address   = REG_CTRL;
    avs_writedata = 32'h3;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    rd(REG_DIALS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clear_wins: got %h expected 0", d); end
    rd(REG_CTRL, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_read: got %h expected 1", d); end
    // Illegal dial 1 step coinciding with the err W1C.
    @(posedge clk);
    #1;
    dial_a[1] = 1'b1;
    dial_b[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    avs_address   = REG_ERR;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    rd(REG_ERR, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL err_set_wins: got %h expected 2", d); end
  endtask

  task automatic test_reset_midscan();
    bit found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (shift_clkin) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midscan_find_hi: shift_clkin never high"); end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (shift_clkin !== 1'b0) begin n_fail++; $display("FAIL midscan_clkin: got %b expected 0", shift_clkin); end
    n_checks++;
    if (shift_load !== 1'b1) begin n_fail++; $display("FAIL midscan_load: got %b expected 1", shift_load); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midscan_irq: got %b expected 0", irq); end
    par = 16'hFFFE;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 3405; e++) begin
      @(posedge clk);
      #1;
      case (e)
        1: begin
          n_checks++;
          if (shift_load !== 1'b0) begin n_fail++; $display("FAIL edge1_load: got %b expected 0", shift_load); end
          avs_address   = REG_CTRL;
          avs_writedata = 32'h1;
          avs_write     = 1'b1;
        end
        2: avs_write = 1'b0;
        25: begin
          n_checks++;
          if (shift_load !== 1'b0) begin n_fail++; $display("FAIL edge25_load: got %b expected 0", shift_load); end
        end
        26: begin
          n_checks++;
          if (shift_load !== 1'b1) begin n_fail++; $display("FAIL edge26_load: got %b expected 1", shift_load); end
        end
        75: begin
          n_checks++;
          if (shift_clkin !== 1'b0) begin n_fail++; $display("FAIL edge75_clkin: got %b expected 0", shift_clkin); end
        end
        76: begin
          n_checks++;
          if (shift_clkin !== 1'b1) begin n_fail++; $display("FAIL edge76_clkin: got %b expected 1", shift_clkin); end
        end
        851: begin
          n_checks++;
          if (shift_load !== 1'b1) begin n_fail++; $display("FAIL edge851_load: got %b expected 1", shift_load); end
        end
        852: begin
          n_checks++;
          if (shift_load !== 1'b0) begin n_fail++; $display("FAIL edge852_load: got %b expected 0", shift_load); end
        end
        3404: begin
          n_checks++;
          if (irq !== 1'b0) begin n_fail++; $display("FAIL edge3404_irq: got %b expected 0", irq); end
        end
        3405: begin
          n_checks++;
          if (irq !== 1'b1) begin n_fail++; $display("FAIL edge3405_irq: got %b expected 1", irq); end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_event_w1c_collision();
    test_dial_count();
    test_dial_err();
    test_collisions();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
